stall_ctrl: RTL
===============

STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001 Parameter WDOG_LIMIT, default 4: maximum consecutive stall cycles before a deadlock error.
REQ-002 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 Port reset, input, 1: asynchronous, active-high reset.
REQ-004 Port stall, input, 1: load-use/branch-operand stall request from the hazard unit; same-cycle combinational.
REQ-005 Port hold, input, 1: external memory-wait request; freezes the whole pipeline.
REQ-006 Port halt_req, input, 1: syscall/halt request decoded in ID.
REQ-007 Port resume, input, 1: leaves HALT; ignored in other states.
REQ-008 Port pc_en, output, 1: PC write enable.
REQ-009 Port ifid_en, output, 1: IF/ID register write enable.
REQ-010 Port idex_clr, output, 1: loads a bubble (all control zero) into ID/EX.
REQ-011 Port exmem_en, output, 1: EX/MEM register write enable.
REQ-012 Port memwb_en, output, 1: MEM/WB register write enable.
REQ-013 Port state, output, 2: current FSM state encoding.
REQ-014 Port wdog_err, output, 1: sticky deadlock flag.

Function
REQ-015 The FSM SHALL have states RUN=2'b00, STALL=2'b01, HOLD=2'b10 and HALT=2'b11.
REQ-016 Priority SHALL be halted > hold > stall > normal.
REQ-017 In HALT: pc_en, ifid_en, exmem_en and memwb_en =0; idex_clr=1.
REQ-018 With hold=1 and not halted: all four enables =0; idex_clr=0; next state HOLD.
REQ-019 With stall=1, hold=0, not halted: pc_en=ifid_en=0, idex_clr=1, exmem_en=memwb_en=1; next state STALL.
REQ-020 Otherwise all enables =1 and idex_clr=0; next state RUN.
REQ-021 Enables SHALL be combinational from the inputs and the current state (zero latency), so a stall is applied in the same cycle it is raised.
REQ-022 The 3-bit consecutive-stall counter SHALL increment on every cycle with stall=1, hold=0 and not halted, saturating at 7.
REQ-023 The counter SHALL keep its value during HOLD cycles and clear on any cycle with stall=0 and hold=0.
REQ-024 When the counter reaches WDOG_LIMIT, wdog_err SHALL set and the FSM SHALL enter HALT on the next edge.
REQ-025 wdog_err SHALL clear only on reset.
REQ-026 halt_req=1 in RUN or STALL with hold=0 SHALL enter HALT on the next edge; the halting instruction itself receives a bubble through idex_clr.
REQ-027 halt_req during hold SHALL be deferred until hold drops.
REQ-028 resume=1 in HALT SHALL go to RUN and clear the counter.
REQ-029 resume SHALL NOT leave HALT while wdog_err=1.
REQ-030 Simultaneous halt_req and resume in HALT: resume wins.

Reset
REQ-031 Reset SHALL force state=RUN, counter=0, wdog_err=0 and, where compiled in, perf counters=0.
REQ-032 Out of reset, outputs SHALL be pc_en=ifid_en=exmem_en=memwb_en=1 and idex_clr=0, given idle inputs.
REQ-033 Reset asserted mid-STALL or mid-HALT SHALL return to RUN immediately, without waiting for a clock edge.

Configuration
REQ-034 With STALL_CTRL_PERF_EN defined: 32-bit outputs stall_cycles and hold_cycles SHALL count qualifying cycles, wrapping from 2^32-1 to 0.
REQ-035 Without STALL_CTRL_PERF_EN: those ports and registers SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-036 A shared package SHALL hold the state encodings RUN, STALL, HOLD and HALT and the default WDOG_LIMIT.
REQ-037 The watchdog counter SHALL be a sub-module stall_wdog (inputs inc, clr, keep; outputs count, hit).

Verification
REQ-038 Reset released, idle inputs -> state=00, all enables 1, idex_clr 0.
REQ-039 stall=1 for 2 cycles -> pc_en=0 and idex_clr=1 in both cycles, wdog_err=0, then RUN.
REQ-040 stall=1 held 4 cycles -> wdog_err=1 after the 4th edge, state=11; resume=1 has no effect.
REQ-041 stall=1 and hold=1 together -> all enables 0, idex_clr=0, counter unchanged; hold drop with stall still 1 -> STALL.
REQ-042 halt_req pulse -> HALT next edge; resume pulse -> RUN, pc_en=1.
REQ-043 Reset asserted mid-HALT -> state=00 combinationally, before the next edge.

Source files
------------

// File: rtl/stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller: FSM state encodings
// and the default deadlock watchdog limit.
package stall_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        STALL = 2'b01,
        HOLD  = 2'b10,
        HALT  = 2'b11
    } state_t;

    localparam int WDOG_LIMIT_DEFAULT = 4;

endpackage

// File: rtl/stall_wdog.sv
// Consecutive-stall watchdog: a 3-bit saturating counter that flags when the
// count reaches LIMIT on the edge being computed.
module stall_wdog
    import stall_ctrl_pkg::*;
#(
    parameter int LIMIT = WDOG_LIMIT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       clr,
    input  logic       keep,
    output logic [2:0] count,
    output logic       hit
);

    logic [2:0] count_next;

    always_comb begin
        count_next = count;
        if (clr) begin
            count_next = '0;
        end else if (keep) begin
            count_next = count;
        end else if (inc && (count != 3'd7)) begin
            count_next = count + 3'd1;
        end
    end

    // hit looks at the value being loaded so the error lands on the same edge
    assign hit = inc && !clr && !keep && (int'(count_next) >= LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall/hold/halt controller with deadlock watchdog.
// Optional macro STALL_CTRL_PERF_EN adds stall_cycles/hold_cycles counters.
module stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter int WDOG_LIMIT = WDOG_LIMIT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        hold,
    input  logic        halt_req,
    input  logic        resume,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_clr,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic [1:0]  state,
`ifdef STALL_CTRL_PERF_EN
    output logic        wdog_err,
    output logic [31:0] stall_cycles,
    output logic [31:0] hold_cycles
`else
    output logic        wdog_err
`endif
);

    state_t     state_q;
    state_t     state_d;
    logic       halted;
    logic       resume_go;
    logic       wdog_inc;
    logic       wdog_keep;
    logic       wdog_clr;
    logic       wdog_hit;
    logic [2:0] wdog_count;

    assign halted    = (state_q == HALT);
    assign resume_go = halted && resume && !wdog_err;
    assign wdog_inc  = stall && !hold && !halted;
    assign wdog_keep = hold && !halted;
    assign wdog_clr  = (!stall && !hold) || resume_go;
    assign state     = state_q;

    stall_wdog #(
        .LIMIT (WDOG_LIMIT)
    ) u_wdog (
        .clk   (clk),
        .reset (reset),
        .inc   (wdog_inc),
        .clr   (wdog_clr),
        .keep  (wdog_keep),
        .count (wdog_count),
        .hit   (wdog_hit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= RUN;
            wdog_err <= 1'b0;
        end else begin
            state_q <= state_d;
            if (wdog_hit) begin
                wdog_err <= 1'b1;
            end
        end
    end

    // Priority: halted > hold > stall > normal; halt_req waits out a hold.
    always_comb begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        idex_clr = 1'b0;
        exmem_en = 1'b1;
        memwb_en = 1'b1;
        state_d  = RUN;
        if (halted) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_clr = 1'b1;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
            state_d  = resume_go ? RUN : HALT;
        end else if (hold) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
            state_d  = HOLD;
        end else begin
            if (stall) begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_clr = 1'b1;
                state_d  = STALL;
            end
            // the halting instruction itself is squashed into a bubble
            if (halt_req) begin
                idex_clr = 1'b1;
            end
            if (halt_req || wdog_hit) begin
                state_d = HALT;
            end
        end
    end

`ifdef STALL_CTRL_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            hold_cycles  <= '0;
        end else begin
            if (wdog_inc) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (wdog_keep) begin
                hold_cycles <= hold_cycles + 32'd1;
            end
        end
    end
`endif

endmodule
